ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
- Execute-stage HI/LO unit directly downstream of the ID/EX pipeline register.
- Consumes the latched rs/rt values and the decoded mult/div/mthi/mtlo/mfhi/mflo controls.
- Computes MULT, MULTU, DIV and DIVU iteratively and holds the HI/LO architectural registers.
- Raises a stall request so the hazard logic freezes IF/ID and ID/EX while a HI/LO access would collide with a running operation.

Parameters:
- DATA_WIDTH, 32, operand/HI/LO width; only 32 supported.
- ITERATIONS, 32, shift-add / restoring-divide steps; must equal DATA_WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- startIn  input  1  launch mult/div this cycle.
- opIn  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rsValueIn  input  32  operand A (multiplicand/dividend).
- rtValueIn  input  32  operand B (multiplier/divisor).
- hiWeIn  input  1  mthi write.
- loWeIn  input  1  mtlo write.
- wdataIn  input  32  mthi/mtlo data.
- readIn  input  1  mfhi/mflo in EX this cycle.
- hiOut  output  32  HI register.
- loOut  output  32  LO register.
- busyOut  output  1  operation in progress.
- doneOut  output  1  one-cycle pulse, HI/LO just updated by mult/div.
- stallOut  output  1  pipeline freeze request (combinational).

Behaviour:
- Reset (async, any state): state=IDLE; hiOut=0, loOut=0, busyOut=0, doneOut=0, counter=0, internal operands=0. An operation in flight is discarded, and HI/LO are not partially updated.
- States: IDLE, CALC, FIX.
- IDLE:
  - startIn=1 at edge E0: latch the operand magnitudes (signed ops take the absolute value), the result sign flags and opIn; counter=0; go to CALC.
  - busyOut=1 from E0.
- CALC:
  - Each edge performs one step and increments the counter.
  - Multiply: 64-bit shift-add on the magnitudes.
  - Divide: restoring, 1 quotient bit per step.
  - After the step with counter=ITERATIONS-1 (edge E32), go to FIX.
- FIX, edge E33:
  - Apply sign correction.
  - Multiply: negate the 64-bit product if signA^signB.
  - Divide: quotient negated if signA^signB; remainder negated if signA.
  - Write HI/LO; busyOut=0; doneOut=1 for exactly the cycle after E33; return to IDLE.
- Latency: results visible on hiOut/loOut 33 cycles after E0.
- Results: MULT/MULTU give HI = product[63:32], LO = product[31:0]. DIV/DIVU give LO = quotient, HI = remainder.
- Divide by zero: completes with normal latency; LO=32'hFFFFFFFF, HI=dividend as supplied (unsigned/raw bits).
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of the magnitude arithmetic; no trap.
- mthi/mtlo:
  - Applied only in IDLE with no start.
  - hiWeIn loads HI, loWeIn loads LO at the edge; both may be asserted together.
  - startIn together with a write in IDLE: start wins and the write is dropped.
- stallOut = busyOut & (startIn | readIn | hiWeIn | loWeIn).
  - While stalled, the request is held by upstream and is not consumed.
  - startIn while busy never restarts or corrupts the running operation.
- hiOut/loOut always reflect the committed registers and are never intermediate values.

Optional Feature:
- Macro: MULDIV_FAST_MULT_EN.
- Defined: MULT/MULTU use a single-cycle 64-bit multiply (signed/unsigned operator). IDLE goes to FIX at E0 with the product latched; HI/LO are written and doneOut pulses after E1; busyOut is high for 1 cycle. Divide is unchanged.
- Undefined: all ops are iterative with 33-cycle latency, as above.

Test Plan:
- Reset, then MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; doneOut exactly 33 cycles after the start edge (1 with MULDIV_FAST_MULT_EN); busyOut low afterwards.
- MULT 0xFFFFFFFD (-3) × 0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIVU 100/7 -> LO=14, HI=2; DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 5/0 -> LO=0xFFFFFFFF, HI=5; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0; both at normal latency.
- Start DIV 100/7; at cycle 5 assert readIn, then startIn (MULTU 2×3), then hiWeIn (0x1234) -> stallOut=1 in each of those cycles. The DIV result (LO=14, HI=2) is unaffected; after done, the mthi replayed in IDLE gives HI=0x1234.
- In IDLE, hiWeIn and loWeIn together with wdataIn=0xCAFEBABE -> HI=LO=0xCAFEBABE next cycle. startIn plus loWeIn together -> LO not written; operation launches.
- Start MULTU, assert rst at CALC counter=10 -> hiOut, loOut, busyOut, doneOut all 0 immediately, with no clock edge needed. After release, MULTU 6×7 -> LO=42, HI=0 with full latency.

Source files
------------

// File: rtl/ex_muldiv.sv
// ex_muldiv: execute-stage HI/LO unit. Runs MULT/MULTU/DIV/DIVU iteratively
// (one shift-add or restoring-divide step per cycle), holds the HI/LO
// architectural registers and requests a pipeline freeze whenever a HI/LO
// access collides with a running operation.
//
// Build option: define MULDIV_FAST_MULT_EN to compute MULT/MULTU with a
// single-cycle 64-bit multiplier (divide remains iterative).
//
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   startIn, opIn       launch request; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rsValueIn/rtValueIn operand A (multiplicand/dividend), operand B
//   hiWeIn/loWeIn       mthi/mtlo write enables, data on wdataIn
//   readIn              mfhi/mflo present in EX
//   hiOut/loOut         committed HI/LO registers
//   busyOut             operation in progress
//   doneOut             one-cycle pulse after HI/LO written by mult/div
//   stallOut            combinational freeze request to hazard logic
//
// state | meaning
// IDLE  | waiting; accepts start or mthi/mtlo
// CALC  | one multiply/divide step per cycle, ITERATIONS steps
// FIX   | sign correction and HI/LO commit
module ex_muldiv #(
    parameter int DATA_WIDTH = 32,
    parameter int ITERATIONS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  startIn,
    input  logic [1:0]            opIn,
    input  logic [DATA_WIDTH-1:0] rsValueIn,
    input  logic [DATA_WIDTH-1:0] rtValueIn,
    input  logic                  hiWeIn,
    input  logic                  loWeIn,
    input  logic [DATA_WIDTH-1:0] wdataIn,
    input  logic                  readIn,
    output logic [DATA_WIDTH-1:0] hiOut,
    output logic [DATA_WIDTH-1:0] loOut,
    output logic                  busyOut,
    output logic                  doneOut,
    output logic                  stallOut
);
    localparam int W = DATA_WIDTH;
    localparam logic [5:0] LAST_STEP = 6'(ITERATIONS - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t         state_q;
    logic [5:0]     cnt_q;
    logic [1:0]     op_q;
    logic [W-1:0]   a_q;       // multiplicand (mult) or divisor (div) magnitude
    logic [2*W-1:0] acc_q;     // {partial product} or {remainder, dividend/quotient}
    logic [W-1:0]   raw_a_q;   // dividend as supplied, for divide-by-zero
    logic           neg_q;     // negate product / quotient
    logic           neg_r_q;   // negate remainder
    logic           dzero_q;
    logic [W-1:0]   hi_q, lo_q;
    logic           busy_q, done_q;

    logic           sign_a, sign_b;
    logic [W-1:0]   mag_a, mag_b;
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    logic [W:0]     div_trial, div_diff;
    logic           div_ge;
    logic [2*W-1:0] div_next;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quot_fix, rem_fix;

    always_comb begin
        sign_a = ~opIn[0] & rsValueIn[W-1];
        sign_b = ~opIn[0] & rtValueIn[W-1];
        mag_a  = sign_a ? -rsValueIn : rsValueIn;
        mag_b  = sign_b ? -rtValueIn : rtValueIn;

        // Shift-add: add multiplicand into the upper half when LSB set, then
        // shift the whole accumulator right, carry included.
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : '0);
        mul_next = {mul_sum, acc_q[W-1:1]};

        // Restoring divide: bring in the next dividend bit, subtract if it fits.
        div_trial = acc_q[2*W-1:W-1];
        div_diff  = div_trial - {1'b0, a_q};
        div_ge    = div_trial >= {1'b0, a_q};
        div_next  = {(div_ge ? div_diff[W-1:0] : div_trial[W-1:0]), acc_q[W-2:0], div_ge};

        prod_fix = neg_q   ? -acc_q          : acc_q;
        quot_fix = neg_q   ? -acc_q[W-1:0]   : acc_q[W-1:0];
        rem_fix  = neg_r_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
    end

`ifdef MULDIV_FAST_MULT_EN
    logic [2*W-1:0] fast_prod;
    always_comb begin
        if (opIn[0])
            fast_prod = {{W{1'b0}}, rsValueIn} * {{W{1'b0}}, rtValueIn};
        else
            fast_prod = {{W{rsValueIn[W-1]}}, rsValueIn} * {{W{rtValueIn[W-1]}}, rtValueIn};
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            acc_q   <= '0;
            raw_a_q <= '0;
            neg_q   <= 1'b0;
            neg_r_q <= 1'b0;
            dzero_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (startIn) begin
                        op_q    <= opIn;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        raw_a_q <= rsValueIn;
                        dzero_q <= (rtValueIn == '0);
                        neg_q   <= sign_a ^ sign_b;
                        state_q <= S_CALC;
                        if (opIn[1]) begin
                            a_q     <= mag_b;
                            acc_q   <= {{W{1'b0}}, mag_a};
                            neg_r_q <= sign_a;
                        end else begin
                            a_q     <= mag_a;
                            acc_q   <= {{W{1'b0}}, mag_b};
                            neg_r_q <= 1'b0;
                        end
`ifdef MULDIV_FAST_MULT_EN
                        // Product is already signed-correct; skip straight to commit.
                        if (!opIn[1]) begin
                            acc_q   <= fast_prod;
                            neg_q   <= 1'b0;
                            state_q <= S_FIX;
                        end
`endif
                    end else begin
                        if (hiWeIn) hi_q <= wdataIn;
                        if (loWeIn) lo_q <= wdataIn;
                    end
                end
                S_CALC: begin
                    acc_q <= op_q[1] ? div_next : mul_next;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == LAST_STEP) state_q <= S_FIX;
                end
                S_FIX: begin
                    if (op_q[1]) begin
                        if (dzero_q) begin
                            lo_q <= '1;
                            hi_q <= raw_a_q;
                        end else begin
                            lo_q <= quot_fix;
                            hi_q <= rem_fix;
                        end
                    end else begin
                        hi_q <= prod_fix[2*W-1:W];
                        lo_q <= prod_fix[W-1:0];
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign hiOut    = hi_q;
    assign loOut    = lo_q;
    assign busyOut  = busy_q;
    assign doneOut  = done_q;
    assign stallOut = busy_q & (startIn | readIn | hiWeIn | loWeIn);

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;
    logic        clk, rst, startIn, hiWeIn, loWeIn, readIn;
    logic [1:0]  opIn;
    logic [31:0] rsValueIn, rtValueIn, wdataIn, hiOut, loOut;
    logic        busyOut, doneOut, stallOut;

    int n_vec = 0;
    int n_err = 0;

`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    ex_muldiv #(.DATA_WIDTH(32), .ITERATIONS(32)) dut (
        .clk(clk), .rst(rst), .startIn(startIn), .opIn(opIn),
        .rsValueIn(rsValueIn), .rtValueIn(rtValueIn),
        .hiWeIn(hiWeIn), .loWeIn(loWeIn), .wdataIn(wdataIn), .readIn(readIn),
        .hiOut(hiOut), .loOut(loOut), .busyOut(busyOut), .doneOut(doneOut),
        .stallOut(stallOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch an operation (caller is 1 time unit after a rising edge) and
    // count edges after the start edge until doneOut is seen, bounded.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        opIn = op; rsValueIn = a; rtValueIn = b; startIn = 1'b1;
        @(posedge clk); #1;
        startIn = 1'b0;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (doneOut) break;
        end
    endtask

    task automatic test_reset();
        n_vec++; if (hiOut !== 32'h0) begin n_err++; $display("FAIL reset_hi got %h want %h", hiOut, 32'h0); end
        n_vec++; if (loOut !== 32'h0) begin n_err++; $display("FAIL reset_lo got %h want %h", loOut, 32'h0); end
        n_vec++; if (busyOut !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busyOut); end
        n_vec++; if (doneOut !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", doneOut); end
        n_vec++; if (stallOut !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", stallOut); end
    endtask

    task automatic test_multu_max();
        int lat;
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
        n_vec++; if (lat !== MUL_LAT) begin n_err++; $display("FAIL multu_max_lat got %0d want %0d", lat, MUL_LAT); end
        n_vec++; if (hiOut !== 32'hFFFFFFFE) begin n_err++; $display("FAIL multu_max_hi got %h want fffffffe", hiOut); end
        n_vec++; if (loOut !== 32'h00000001) begin n_err++; $display("FAIL multu_max_lo got %h want 00000001", loOut); end
        @(posedge clk); #1;
        n_vec++; if (busyOut !== 1'b0) begin n_err++; $display("FAIL multu_max_busy got %b want 0", busyOut); end
        n_vec++; if (doneOut !== 1'b0) begin n_err++; $display("FAIL multu_max_done_pulse got %b want 0", doneOut); end
    endtask

    task automatic test_signed_ops();
        int lat;
        run_op(2'b00, 32'hFFFFFFFD, 32'h00000007, lat);
        n_vec++; if (lat !== MUL_LAT) begin n_err++; $display("FAIL mult_lat got %0d want %0d", lat, MUL_LAT); end
        n_vec++; if (hiOut !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mult_hi got %h want ffffffff", hiOut); end
        n_vec++; if (loOut !== 32'hFFFFFFEB) begin n_err++; $display("FAIL mult_lo got %h want ffffffeb", loOut); end
        run_op(2'b11, 32'd100, 32'd7, lat);
        n_vec++; if (lat !== DIV_LAT) begin n_err++; $display("FAIL divu_lat got %0d want %0d", lat, DIV_LAT); end
        n_vec++; if (loOut !== 32'd14) begin n_err++; $display("FAIL divu_lo got %h want 0000000e", loOut); end
        n_vec++; if (hiOut !== 32'd2) begin n_err++; $display("FAIL divu_hi got %h want 00000002", hiOut); end
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, lat);
        n_vec++; if (loOut !== 32'hFFFFFFFD) begin n_err++; $display("FAIL div_neg_lo got %h want fffffffd", loOut); end
        n_vec++; if (hiOut !== 32'hFFFFFFFF) begin n_err++; $display("FAIL div_neg_hi got %h want ffffffff", hiOut); end
    endtask

    task automatic test_div_edges();
        int lat;
        run_op(2'b11, 32'd5, 32'd0, lat);
        n_vec++; if (lat !== DIV_LAT) begin n_err++; $display("FAIL divzero_lat got %0d want %0d", lat, DIV_LAT); end
        n_vec++; if (loOut !== 32'hFFFFFFFF) begin n_err++; $display("FAIL divzero_lo got %h want ffffffff", loOut); end
        n_vec++; if (hiOut !== 32'd5) begin n_err++; $display("FAIL divzero_hi got %h want 00000005", hiOut); end
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, lat);
        n_vec++; if (lat !== DIV_LAT) begin n_err++; $display("FAIL divovf_lat got %0d want %0d", lat, DIV_LAT); end
        n_vec++; if (loOut !== 32'h80000000) begin n_err++; $display("FAIL divovf_lo got %h want 80000000", loOut); end
        n_vec++; if (hiOut !== 32'h0) begin n_err++; $display("FAIL divovf_hi got %h want 00000000", hiOut); end
    endtask

    task automatic test_stall();
        int n;
        opIn = 2'b10; rsValueIn = 32'd100; rtValueIn = 32'd7; startIn = 1'b1;
        @(posedge clk); #1;
        startIn = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        n = 5;
        readIn = 1'b1; #1;
        n_vec++; if (stallOut !== 1'b1) begin n_err++; $display("FAIL stall_read got %b want 1", stallOut); end
        readIn = 1'b0;
        opIn = 2'b01; rsValueIn = 32'd2; rtValueIn = 32'd3; startIn = 1'b1; #1;
        n_vec++; if (stallOut !== 1'b1) begin n_err++; $display("FAIL stall_start got %b want 1", stallOut); end
        @(posedge clk); #1; n++;
        startIn = 1'b0;
        hiWeIn = 1'b1; wdataIn = 32'h1234; #1;
        n_vec++; if (stallOut !== 1'b1) begin n_err++; $display("FAIL stall_mthi got %b want 1", stallOut); end
        while (n < 100) begin
            @(posedge clk); #1; n++;
            if (doneOut) break;
        end
        n_vec++; if (n !== DIV_LAT) begin n_err++; $display("FAIL stall_div_lat got %0d want %0d", n, DIV_LAT); end
        n_vec++; if (loOut !== 32'd14) begin n_err++; $display("FAIL stall_div_lo got %h want 0000000e", loOut); end
        n_vec++; if (hiOut !== 32'd2) begin n_err++; $display("FAIL stall_div_hi got %h want 00000002", hiOut); end
        @(posedge clk); #1;
        hiWeIn = 1'b0;
        n_vec++; if (hiOut !== 32'h1234) begin n_err++; $display("FAIL replay_mthi got %h want 00001234", hiOut); end
        n_vec++; if (loOut !== 32'd14) begin n_err++; $display("FAIL replay_lo got %h want 0000000e", loOut); end
    endtask

    task automatic test_mthi_mtlo();
        int n;
        hiWeIn = 1'b1; loWeIn = 1'b1; wdataIn = 32'hCAFEBABE;
        @(posedge clk); #1;
        hiWeIn = 1'b0; loWeIn = 1'b0;
        n_vec++; if (hiOut !== 32'hCAFEBABE) begin n_err++; $display("FAIL mthi_both got %h want cafebabe", hiOut); end
        n_vec++; if (loOut !== 32'hCAFEBABE) begin n_err++; $display("FAIL mtlo_both got %h want cafebabe", loOut); end
        opIn = 2'b01; rsValueIn = 32'd3; rtValueIn = 32'd5; startIn = 1'b1;
        loWeIn = 1'b1; wdataIn = 32'h11111111;
        @(posedge clk); #1;
        startIn = 1'b0; loWeIn = 1'b0;
        n_vec++; if (loOut !== 32'hCAFEBABE) begin n_err++; $display("FAIL start_wins_lo got %h want cafebabe", loOut); end
        n_vec++; if (busyOut !== 1'b1) begin n_err++; $display("FAIL start_wins_busy got %b want 1", busyOut); end
        n = 0;
        while (n < 100) begin
            @(posedge clk); #1; n++;
            if (doneOut) break;
        end
        n_vec++; if (loOut !== 32'd15) begin n_err++; $display("FAIL start_wins_result_lo got %h want 0000000f", loOut); end
        n_vec++; if (hiOut !== 32'd0) begin n_err++; $display("FAIL start_wins_result_hi got %h want 00000000", hiOut); end
    endtask

    task automatic test_reset_midop();
        int lat;
        opIn = 2'b01; rsValueIn = 32'hFFFFFFFF; rtValueIn = 32'hFFFFFFFF; startIn = 1'b1;
        @(posedge clk); #1;
        startIn = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        rst = 1'b1; #1;
        n_vec++; if (hiOut !== 32'h0) begin n_err++; $display("FAIL midrst_hi got %h want 00000000", hiOut); end
        n_vec++; if (loOut !== 32'h0) begin n_err++; $display("FAIL midrst_lo got %h want 00000000", loOut); end
        n_vec++; if (busyOut !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", busyOut); end
        n_vec++; if (doneOut !== 1'b0) begin n_err++; $display("FAIL midrst_done got %b want 0", doneOut); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(2'b01, 32'd6, 32'd7, lat);
        n_vec++; if (lat !== MUL_LAT) begin n_err++; $display("FAIL postrst_lat got %0d want %0d", lat, MUL_LAT); end
        n_vec++; if (loOut !== 32'd42) begin n_err++; $display("FAIL postrst_lo got %h want 0000002a", loOut); end
        n_vec++; if (hiOut !== 32'd0) begin n_err++; $display("FAIL postrst_hi got %h want 00000000", hiOut); end
    endtask

    initial begin
        rst = 1'b1; startIn = 1'b0; opIn = 2'b00; rsValueIn = '0; rtValueIn = '0;
        hiWeIn = 1'b0; loWeIn = 1'b0; wdataIn = '0; readIn = 1'b0;
        #2;
        test_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        test_multu_max();
        test_signed_ops();
        test_div_edges();
        test_stall();
        test_mthi_mtlo();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
